// File: rtl/compute_memory_responder_if.sv
// Bus bundle for compute_memory_responder: compute addr/we/q port,
// host valid/ready load/readback port and result write-back controls.
interface compute_memory_responder_if #(
  parameter int AW = 6
);
  logic          comp_active;
  logic [AW-1:0] addr;
  logic          we;
  logic [7:0]    comp_wdata;
  logic [7:0]    q;
  logic          host_valid;
  logic          host_ready;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [7:0]    host_wdata;
  logic [7:0]    host_rdata;
  logic          host_rvalid;
  logic          wb_start;
  logic [7:0]    c11;
  logic [7:0]    c12;
  logic [7:0]    c21;
  logic [7:0]    c22;
  logic          wb_busy;
  logic          wb_done;
  logic          parity_err;

  modport master (
    output comp_active, addr, we, comp_wdata,
    output host_valid, host_we, host_addr, host_wdata,
    output wb_start, c11, c12, c21, c22,
    input  q, host_ready, host_rdata, host_rvalid,
    input  wb_busy, wb_done, parity_err
  );

  modport slave (
    input  comp_active, addr, we, comp_wdata,
    input  host_valid, host_we, host_addr, host_wdata,
    input  wb_start, c11, c12, c21, c22,
    output q, host_ready, host_rdata, host_rvalid,
    output wb_busy, wb_done, parity_err
  );
endinterface

// File: rtl/compute_memory_responder.sv
// 64x8 scratch memory: compute > write-back > host, one access per cycle.
// Define MEM_PARITY_EN to store an even-parity bit per word with sticky error.
module compute_memory_responder #(
  parameter int             AW          = 6,
  parameter int             DEPTH       = 2**AW,
  parameter logic [AW-1:0]  RESULT_BASE = 6'd60
) (
  input logic clk,
  input logic rst,
  compute_memory_responder_if.slave bus
);

`ifdef MEM_PARITY_EN
  localparam int WW = 9;
`else
  localparam int WW = 8;
`endif

  typedef enum logic [2:0] {
    IDLE,
    WB0,
    WB1,
    WB2,
    WB3
  } wb_state_e;

  wb_state_e     state_q, state_d;
  logic [7:0]    res_q [4];
  logic          done_q, done_d;
  logic          wb_we;
  logic [1:0]    wb_idx;

  logic [WW-1:0] mem_q [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;
  logic [WW-1:0] comp_word;
  logic [WW-1:0] host_word;

  logic [7:0]    q_q;
  logic [7:0]    rdata_q;
  logic          rvalid_q;
  logic          host_ready;
  logic          host_xfer;
  logic          host_rd;
  logic          comp_rd;

  assign host_ready = !bus.comp_active && (state_q == IDLE);
  assign host_xfer  = host_ready && bus.host_valid;
  assign host_rd    = host_xfer && !bus.host_we;
  assign comp_rd    = bus.comp_active && !bus.we;
  assign comp_word  = mem_q[bus.addr];
  assign host_word  = mem_q[bus.host_addr];

  // The whole FSM freezes while compute owns the memory.
  always_comb begin
    state_d = state_q;
    wb_we   = 1'b0;
    wb_idx  = 2'd0;
    done_d  = 1'b0;
    if (!bus.comp_active) begin
      unique case (state_q)
        IDLE: if (bus.wb_start) state_d = WB0;
        WB0: begin
          wb_we   = 1'b1;
          wb_idx  = 2'd0;
          state_d = WB1;
        end
        WB1: begin
          wb_we   = 1'b1;
          wb_idx  = 2'd1;
          state_d = WB2;
        end
        WB2: begin
          wb_we   = 1'b1;
          wb_idx  = 2'd2;
          state_d = WB3;
        end
        WB3: begin
          wb_we   = 1'b1;
          wb_idx  = 2'd3;
          state_d = IDLE;
          done_d  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.host_addr;
    mem_wdata = bus.host_wdata;
    if (bus.comp_active) begin
      mem_we    = bus.we;
      mem_waddr = bus.addr;
      mem_wdata = bus.comp_wdata;
    end else if (wb_we) begin
      mem_we    = 1'b1;
      mem_waddr = RESULT_BASE + {{(AW-2){1'b0}}, wb_idx};
      mem_wdata = res_q[wb_idx];
    end else begin
      mem_we    = host_xfer && bus.host_we;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
`ifdef MEM_PARITY_EN
      mem_q[mem_waddr] <= {^mem_wdata, mem_wdata};
`else
      mem_q[mem_waddr] <= mem_wdata;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      q_q      <= 8'd0;
      rdata_q  <= 8'd0;
      rvalid_q <= 1'b0;
      res_q    <= '{default: 8'd0};
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      rvalid_q <= host_rd;
      if (bus.comp_active) begin
        q_q <= bus.we ? bus.comp_wdata : comp_word[7:0];
      end
      if (host_rd) begin
        rdata_q <= host_word[7:0];
      end
      if (state_q == IDLE && state_d == WB0) begin
        res_q <= '{bus.c11, bus.c12, bus.c21, bus.c22};
      end
    end
  end

`ifdef MEM_PARITY_EN
  logic perr_q, perr_d;

  // A good word has an even number of ones across data and parity.
  always_comb begin
    perr_d = perr_q;
    if (comp_rd && ^comp_word) perr_d = 1'b1;
    if (host_rd && ^host_word) perr_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) perr_q <= 1'b0;
    else     perr_q <= perr_d;
  end

  assign bus.parity_err = perr_q;
`else
  logic unused_comp_rd;
  assign unused_comp_rd = comp_rd;
  assign bus.parity_err = 1'b0;
`endif

  assign bus.q           = q_q;
  assign bus.host_ready  = host_ready;
  assign bus.host_rdata  = rdata_q;
  assign bus.host_rvalid = rvalid_q;
  assign bus.wb_busy     = (state_q != IDLE);
  assign bus.wb_done     = done_q;

endmodule

// File: tb/tb_compute_memory_responder.sv
// Randomized self-checking bench for compute_memory_responder against a
// transaction-level model (memory array plus a queue of pending result writes).
module tb_compute_memory_responder;

  localparam logic [5:0] RB = 6'd62;

  typedef struct {
    logic [5:0] a;
    logic [7:0] d;
  } wr_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  compute_memory_responder_if #(.AW(6)) bus ();

  compute_memory_responder #(
    .AW          (6),
    .RESULT_BASE (RB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] m_mem [64];
  bit         m_bad [64];
  wr_t        wbq [$];
  logic [7:0] e_q;
  logic [7:0] e_rdata;
  bit         e_rvalid;
  bit         e_done;
  bit         e_perr;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    wbq.delete();
    e_q      = 8'd0;
    e_rdata  = 8'd0;
    e_rvalid = 0;
    e_done   = 0;
    e_perr   = 0;
  endfunction

  // One clock edge of the reference: which single access happens, and its effect.
  function automatic void model_edge();
    wr_t w;
    bit  idle;
    idle     = (wbq.size() == 0);
    e_done   = 0;
    e_rvalid = 0;
    if (bus.comp_active) begin
      if (bus.we) begin
        m_mem[bus.addr] = bus.comp_wdata;
        m_bad[bus.addr] = 0;
        e_q = bus.comp_wdata;
      end else begin
        e_q = m_mem[bus.addr];
        if (m_bad[bus.addr]) e_perr = 1;
      end
    end else if (!idle) begin
      w = wbq.pop_front();
      m_mem[w.a] = w.d;
      m_bad[w.a] = 0;
      if (wbq.size() == 0) e_done = 1;
    end else begin
      if (bus.host_valid) begin
        if (bus.host_we) begin
          m_mem[bus.host_addr] = bus.host_wdata;
          m_bad[bus.host_addr] = 0;
        end else begin
          e_rdata  = m_mem[bus.host_addr];
          e_rvalid = 1;
          if (m_bad[bus.host_addr]) e_perr = 1;
        end
      end
      if (bus.wb_start) begin
        wbq.push_back('{RB + 6'd0, bus.c11});
        wbq.push_back('{RB + 6'd1, bus.c12});
        wbq.push_back('{RB + 6'd2, bus.c21});
        wbq.push_back('{RB + 6'd3, bus.c22});
      end
    end
  endfunction

  task automatic check_outputs();
    check("q", bus.q, e_q);
    check("host_rdata", bus.host_rdata, e_rdata);
    check("host_rvalid", bus.host_rvalid, e_rvalid);
    check("wb_busy", bus.wb_busy, wbq.size() != 0);
    check("wb_done", bus.wb_done, e_done);
    check("parity_err", bus.parity_err, e_perr);
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    #1;
    check("host_ready", bus.host_ready,
          !bus.comp_active && wbq.size() == 0);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.comp_active = 0;
    bus.addr        = '0;
    bus.we          = 0;
    bus.comp_wdata  = '0;
    bus.host_valid  = 0;
    bus.host_we     = 0;
    bus.host_addr   = '0;
    bus.host_wdata  = '0;
    bus.wb_start    = 0;
  endtask

  task automatic host_op(input bit wr, input logic [5:0] a,
                         input logic [7:0] d);
    idle_inputs();
    bus.host_valid = 1;
    bus.host_we    = wr;
    bus.host_addr  = a;
    bus.host_wdata = d;
    step();
    idle_inputs();
  endtask

  task automatic wb_latency(input string tag, input int stall_at,
                            input int stall_len, input int exp_lat);
    int n;
    idle_inputs();
    bus.wb_start = 1;
    bus.c11 = 8'd1;
    bus.c12 = 8'd2;
    bus.c21 = 8'd3;
    bus.c22 = 8'd4;
    step();
    bus.wb_start = 0;
    bus.c11 = 8'hEE;
    n = 1;
    while (!bus.wb_done && n < 30) begin
      bus.comp_active = (n >= stall_at && n < stall_at + stall_len);
      bus.wb_start    = bus.comp_active;
      bus.addr        = 6'(n);
      step();
      n++;
    end
    idle_inputs();
    check(tag, n, exp_lat);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1;
    idle_inputs();
    bus.c11 = '0;
    bus.c12 = '0;
    bus.c21 = '0;
    bus.c22 = '0;
    for (int i = 0; i < 64; i++) m_bad[i] = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    check("rst_host_ready", bus.host_ready, 1'b1);
    @(negedge clk);
    rst = 0;

    for (int k = 0; k < 64; k++) host_op(1, 6'(k), 8'(k));

    host_op(1, 6'd3, 8'hA5);
    host_op(0, 6'd3, 8'h00);
    check("rd3_value", bus.host_rdata, 8'hA5);
    check("rd3_rvalid", bus.host_rvalid, 1'b1);
    step();
    check("rd3_pulse", bus.host_rvalid, 1'b0);

    for (int k = 0; k < 8; k++) begin
      bus.comp_active = 1;
      bus.addr        = 6'(k);
      step();
      check("comp_rd", bus.q, 8'(k == 3 ? 8'hA5 : k));
    end
    bus.we = 1;
    bus.addr = 6'd5;
    bus.comp_wdata = 8'h3C;
    step();
    check("comp_wr_first", bus.q, 8'h3C);
    bus.we = 0;
    bus.addr = 6'd6;
    step();
    bus.addr = 6'd5;
    step();
    check("comp_rd5", bus.q, 8'h3C);
    idle_inputs();

    wb_latency("wb_lat", 99, 0, 5);
    host_op(0, 6'd62, 8'h00);
    check("wb62", bus.host_rdata, 8'd1);
    host_op(0, 6'd0, 8'h00);
    check("wb0_wrap", bus.host_rdata, 8'd3);
    host_op(0, 6'd1, 8'h00);
    host_op(0, 6'd63, 8'h00);

    wb_latency("wb_stall_lat", 2, 3, 8);

`ifdef MEM_PARITY_EN
    dut.mem_q[9][8] = ~dut.mem_q[9][8];
    m_bad[9] = 1;
    host_op(0, 6'd9, 8'h00);
    check("perr_set", bus.parity_err, 1'b1);
    repeat (3) step();
`endif

    for (int i = 0; i < 600; i++) begin
      bus.comp_active = ($urandom_range(0, 99) < 30);
      bus.we          = $urandom_range(0, 1);
      bus.addr        = 6'($urandom);
      bus.comp_wdata  = 8'($urandom);
      bus.host_valid  = $urandom_range(0, 1);
      bus.host_we     = $urandom_range(0, 1);
      bus.host_addr   = 6'($urandom);
      bus.host_wdata  = 8'($urandom);
      bus.wb_start    = ($urandom_range(0, 99) < 8);
      bus.c11         = 8'($urandom);
      bus.c12         = 8'($urandom);
      bus.c21         = 8'($urandom);
      bus.c22         = 8'($urandom);
      step();
    end
    idle_inputs();

    bus.wb_start = 1;
    step();
    bus.wb_start = 0;
    step();
    #2;
    rst = 1;
    #1;
    check("rst_busy", bus.wb_busy, 1'b0);
    check("rst_done", bus.wb_done, 1'b0);
    check("rst_perr", bus.parity_err, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 0;
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
